// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch front end for a byte-wide instruction memory.
//   It issues one sequential fetch per cycle and redirects on taken
//   branches with no bubble. A one-entry skid buffer holds the byte that
//   is still in flight when a stall begins. A branch to its own opcode
//   address stops fetch until the next reset.
//
// Ports
//   CLK, RSTN        clock; synchronous active-low reset
//   STALL            hold fetch while a data-memory access is in progress
//   FLAG_WE          load N/Z/P from FLAG_DATA on the next edge
//   FLAG_DATA[3:0]   result value used to derive N/Z/P
//   IS_BRN/Z/P       branch condition mask (target-byte cycle only)
//   BR_TARGET        branch destination, valid with IS_BR*
//   IMEM_ADDR/EN     instruction memory read address / enable
//   IMEM_RDATA       read data, one cycle after an enabled address
//   INSTR            byte to the decoder, 0x00 whenever INSTR_VALID=0
//   INSTR_VALID      INSTR carries a real fetched byte
//   FLAGS            {N,Z,P}
//   HALTED           self-branch detected, fetch stopped
//   STATE_DBG        current FSM state (debug observation only)
//
// Handshake: there is no back-pressure from the decoder. Each cycle in
// which INSTR_VALID=1 hands over exactly one byte, in program order.
// STALL is the only throttle, and it can be deferred by one cycle so that
// a branch opcode and its target byte always arrive back to back.
module fetch_unit #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 8
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               STALL,
  input  logic               FLAG_WE,
  input  logic [3:0]         FLAG_DATA,
  input  logic               IS_BRN,
  input  logic               IS_BRZ,
  input  logic               IS_BRP,
  input  logic [PC_W-1:0]    BR_TARGET,
  output logic [PC_W-1:0]    IMEM_ADDR,
  output logic               IMEM_EN,
  input  logic [INSTR_W-1:0] IMEM_RDATA,
  output logic [INSTR_W-1:0] INSTR,
  output logic               INSTR_VALID,
  output logic [2:0]         FLAGS,
  output logic               HALTED,
  output logic [1:0]         STATE_DBG
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W-1:0]      iaddr_q;
  logic [INSTR_W-1:0]   skid_q;
  logic                 skid_vld_q;
  logic                 fetched_q;   // an enabled fetch was issued last cycle
  logic                 n_q, z_q, p_q;

  logic                 fetch_en;
  logic [PC_W-1:0]      fetch_addr;
  logic [INSTR_W-1:0]   instr;
  logic                 instr_vld;
  logic                 taken;
  logic                 halt_hit;
  logic [PC_W-1:0]      iaddr_prev;

  // The target byte sits one address after its opcode, so a branch whose
  // destination equals iaddr_q-1 jumps back onto itself.
  assign iaddr_prev = iaddr_q - PC_W'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_en   = 1'b0;
    fetch_addr = pc_q;
    instr      = '0;
    instr_vld  = 1'b0;
    taken      = 1'b0;
    halt_hit   = 1'b0;
    case (state_q)
      S_RUN: begin
        // A parked skid byte is always older than anything in flight.
        instr_vld = skid_vld_q | fetched_q;
        if (skid_vld_q)     instr = skid_q;
        else if (fetched_q) instr = IMEM_RDATA;
        taken    = instr_vld & ((IS_BRN & n_q) | (IS_BRZ & z_q) | (IS_BRP & p_q));
        halt_hit = taken && (BR_TARGET == iaddr_prev);
        if (halt_hit) begin
          state_d = S_HALT;
        end else begin
          // The stall-request cycle still issues its fetch; that byte lands
          // in the skid buffer. This also lets a taken branch finish its
          // redirect before the stall takes hold.
          fetch_en = 1'b1;
          if (taken) fetch_addr = BR_TARGET;
          pc_d = fetch_addr + PC_W'(1);
          if (STALL && !(instr_vld && instr[6:4] == 3'b011)) state_d = S_STALL;
        end
      end
      S_STALL: begin
        if (!STALL) state_d = S_RUN;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= S_RUN;
      pc_q       <= '0;
      iaddr_q    <= '0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      fetched_q  <= 1'b0;
      n_q        <= 1'b0;
      z_q        <= 1'b1;
      p_q        <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      fetched_q <= fetch_en;
      if (fetch_en) iaddr_q <= fetch_addr;
      if (state_q == S_RUN) begin
        skid_vld_q <= 1'b0;
      end else if (state_q == S_STALL && fetched_q) begin
        skid_q     <= IMEM_RDATA;
        skid_vld_q <= 1'b1;
      end
      if (FLAG_WE) begin
        n_q <= FLAG_DATA[3];
        z_q <= (FLAG_DATA == 4'd0);
        p_q <= ~FLAG_DATA[3] & (FLAG_DATA != 4'd0);
      end
    end
  end

  assign IMEM_ADDR   = fetch_addr;
  assign IMEM_EN     = fetch_en & RSTN;
  assign INSTR       = instr;
  assign INSTR_VALID = instr_vld;
  assign FLAGS       = {n_q, z_q, p_q};
  assign HALTED      = (state_q == S_HALT);
  assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
//   Directed checks of reset, sequential fetch, taken/not-taken branches,
//   stall/skid behaviour, branch-over-stall priority, halt and PC wrap,
//   followed by a randomized run checked against a program-order model
//   of the instruction stream.
module tb_fetch_unit;
  localparam int PC_W    = 7;
  localparam int INSTR_W = 8;

  logic               CLK = 1'b0;
  logic               RSTN = 1'b0;
  logic               STALL = 1'b0;
  logic               FLAG_WE = 1'b0;
  logic [3:0]         FLAG_DATA = '0;
  logic               IS_BRN = 1'b0, IS_BRZ = 1'b0, IS_BRP = 1'b0;
  logic [PC_W-1:0]    BR_TARGET = '0;
  logic [PC_W-1:0]    IMEM_ADDR;
  logic               IMEM_EN;
  logic [INSTR_W-1:0] IMEM_RDATA = '0;
  logic [INSTR_W-1:0] INSTR;
  logic               INSTR_VALID;
  logic [2:0]         FLAGS;
  logic               HALTED;
  logic [1:0]         STATE_DBG;

  logic [INSTR_W-1:0] mem [128];
  logic [INSTR_W-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .CLK(CLK), .RSTN(RSTN), .STALL(STALL), .FLAG_WE(FLAG_WE),
    .FLAG_DATA(FLAG_DATA), .IS_BRN(IS_BRN), .IS_BRZ(IS_BRZ), .IS_BRP(IS_BRP),
    .BR_TARGET(BR_TARGET), .IMEM_ADDR(IMEM_ADDR), .IMEM_EN(IMEM_EN),
    .IMEM_RDATA(IMEM_RDATA), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .FLAGS(FLAGS), .HALTED(HALTED), .STATE_DBG(STATE_DBG)
  );

  // clock and synchronous instruction memory
  always #5 CLK = ~CLK;
  always @(posedge CLK) if (IMEM_EN) IMEM_RDATA <= mem[IMEM_ADDR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and return inputs to idle.
  task automatic next_cycle();
    @(posedge CLK); #1;
    STALL = 1'b0; FLAG_WE = 1'b0; FLAG_DATA = '0;
    IS_BRN = 1'b0; IS_BRZ = 1'b0; IS_BRP = 1'b0; BR_TARGET = '0;
  endtask

  // Byte = its own address, with 0x30..0x3F remapped so no opcode appears.
  task automatic fill_default();
    for (int a = 0; a < 128; a++)
      mem[a] = (((a >> 4) & 7) == 3) ? 8'(a ^ 8'hC0) : 8'(a);
  endtask

  // Ends in the first cycle with RSTN high, outputs settled.
  task automatic do_reset();
    RSTN = 1'b0;
    next_cycle(); next_cycle(); #1;
    chk("rst_valid",  32'(INSTR_VALID), 32'd0);
    chk("rst_instr",  32'(INSTR),       32'd0);
    chk("rst_halted", 32'(HALTED),      32'd0);
    chk("rst_flags",  32'(FLAGS),       32'b010);
    RSTN = 1'b1; #1;
    chk("rel_addr",  32'(IMEM_ADDR),   32'd0);
    chk("rel_en",    32'(IMEM_EN),     32'd1);
    chk("rel_valid", 32'(INSTR_VALID), 32'd0);
  endtask

  // Opcode at 5, target byte at 6; stops inside the target-byte cycle with
  // the branch mask and destination applied.
  task automatic to_target(input logic [3:0] fd, input logic [2:0] mask, input logic [6:0] tgt);
    fill_default();
    mem[5] = 8'h30; mem[6] = 8'h40; mem[7'h40] = 8'hA5;
    do_reset();
    FLAG_WE = 1'b1; FLAG_DATA = fd;
    repeat (6) next_cycle();
    #1;
    chk("op_byte", 32'(INSTR), 32'h30);
    next_cycle();
    {IS_BRN, IS_BRZ, IS_BRP} = mask; BR_TARGET = tgt;
    #1;
    chk("tgt_valid", 32'(INSTR_VALID), 32'd1);
    chk("tgt_byte",  32'(INSTR),       32'h40);
  endtask

  initial begin
    int lows;
    logic [6:0] m_addr, op_addr, t;
    logic [2:0] mask;
    logic mn, mz, mp, tgt_now, prev_stall, stall_v;

    // sequential fetch from reset
    fill_default();
    mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      chk("seq_valid", 32'(INSTR_VALID), 32'd1);
      chk("seq_byte",  32'(INSTR),       32'(8'h10 + i));
    end

    // taken branch on Z, zero bubbles
    to_target(4'h0, 3'b010, 7'h40);
    chk("brz_flags", 32'(FLAGS),     32'b010);
    chk("brz_addr",  32'(IMEM_ADDR), 32'h40);
    chk("brz_en",    32'(IMEM_EN),   32'd1);
    next_cycle(); #1;
    chk("brz_dest_v", 32'(INSTR_VALID), 32'd1);
    chk("brz_dest",   32'(INSTR),       32'hA5);
    next_cycle(); #1;
    chk("brz_next",   32'(INSTR),       32'h41);

    // P set, only N tested: not taken
    to_target(4'h3, 3'b100, 7'h40);
    chk("nt_flags", 32'(FLAGS),     32'b001);
    chk("nt_addr",  32'(IMEM_ADDR), 32'h07);
    next_cycle(); #1;
    chk("nt_next",  32'(INSTR),     32'h07);

    // PC wraps from 0x7F to 0x00
    to_target(4'h0, 3'b010, 7'h7E);
    next_cycle(); #1;
    chk("wrap_7e",   32'(INSTR),     32'h7E);
    chk("wrap_a7f",  32'(IMEM_ADDR), 32'h7F);
    next_cycle(); #1;
    chk("wrap_7f",   32'(INSTR),     32'h7F);
    chk("wrap_a00",  32'(IMEM_ADDR), 32'h00);
    next_cycle(); #1;
    chk("wrap_00",   32'(INSTR),     32'h00);

    // three-cycle stall mid-stream: nothing lost, duplicated or reordered
    fill_default();
    do_reset();
    exp_q.delete();
    for (int a = 0; a < 7; a++) exp_q.push_back(mem[a]);
    lows = 0;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      STALL = (c >= 3 && c <= 5);
      #1;
      if (INSTR_VALID) begin
        chk("stall_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("stall_order", 32'(INSTR), 32'(exp_q.pop_front()));
      end else begin
        lows++;
      end
    end
    chk("stall_lows", 32'(lows), 32'd3);
    chk("stall_left", 32'(exp_q.size()), 32'd0);

    // stall on an opcode is deferred; taken branch beats stall
    fill_default();
    mem[2] = 8'h30; mem[3] = 8'h50; mem[7'h40] = 8'hA5;
    do_reset();
    next_cycle(); next_cycle();
    next_cycle(); STALL = 1'b1; #1;
    chk("dfr_op", 32'(INSTR), 32'h30);
    next_cycle(); STALL = 1'b1; IS_BRZ = 1'b1; BR_TARGET = 7'h40; #1;
    chk("dfr_tgt_v", 32'(INSTR_VALID), 32'd1);
    chk("dfr_tgt",   32'(INSTR),       32'h50);
    chk("dfr_addr",  32'(IMEM_ADDR),   32'h40);
    next_cycle(); #1;
    chk("dfr_stalled", 32'(INSTR_VALID), 32'd0);
    next_cycle(); #1;
    chk("dfr_skid_v", 32'(INSTR_VALID), 32'd1);
    chk("dfr_skid",   32'(INSTR),       32'hA5);

    // branch to itself halts; flags still load; reset restarts at 0
    fill_default();
    mem[7'h20] = 8'h30;
    do_reset();
    repeat (7'h21) next_cycle();
    #1;
    chk("halt_op", 32'(INSTR), 32'h30);
    next_cycle(); IS_BRN = 1'b1; IS_BRZ = 1'b1; IS_BRP = 1'b1; BR_TARGET = 7'h20; #1;
    chk("halt_tgt", 32'(INSTR), 32'h21);
    next_cycle(); STALL = 1'b1; FLAG_WE = 1'b1; FLAG_DATA = 4'h8; #1;
    chk("halted",       32'(HALTED),      32'd1);
    chk("halt_en",      32'(IMEM_EN),     32'd0);
    chk("halt_valid",   32'(INSTR_VALID), 32'd0);
    next_cycle(); #1;
    chk("halt_hold",    32'(HALTED),      32'd1);
    chk("halt_flags",   32'(FLAGS),       32'b100);
    chk("halt_en2",     32'(IMEM_EN),     32'd0);
    do_reset();
    next_cycle(); #1;
    chk("restart_v", 32'(INSTR_VALID), 32'd1);
    chk("restart",   32'(INSTR),       32'(mem[0]));

    // randomized program with random stalls, flag writes and branches
    for (int a = 0; a < 128; a++) begin
      mem[a] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) mem[a][6:4] = 3'b011;
    end
    do_reset();
    m_addr = '0; op_addr = '0; t = '0; mask = '0;
    mn = 1'b0; mz = 1'b1; mp = 1'b0;
    tgt_now = 1'b0; prev_stall = 1'b0;
    exp_q.delete();
    exp_q.push_back(mem[0]);
    for (int c = 0; c < 1500; c++) begin
      next_cycle();
      stall_v = ($urandom_range(0, 3) == 0);
      STALL = stall_v;
      if ($urandom_range(0, 3) == 0) begin
        FLAG_WE = 1'b1; FLAG_DATA = 4'($urandom_range(0, 15));
      end
      if (tgt_now) begin
        mask = 3'($urandom_range(0, 7));
        {IS_BRN, IS_BRZ, IS_BRP} = mask;
        do t = 7'($urandom_range(0, 127)); while (t == op_addr);
        BR_TARGET = t;
      end
      #1;
      chk("rnd_flags",   32'(FLAGS),  32'({mn, mz, mp}));
      chk("rnd_nohalt",  32'(HALTED), 32'd0);
      if (!INSTR_VALID) chk("rnd_idle_zero", 32'(INSTR), 32'd0);
      if (tgt_now)      chk("rnd_tgt_b2b", 32'(INSTR_VALID), 32'd1);
      if (!prev_stall)  chk("rnd_progress", 32'(INSTR_VALID), 32'd1);
      if (INSTR_VALID) begin
        chk("rnd_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("rnd_stream", 32'(INSTR), 32'(exp_q.pop_front()));
        if (tgt_now) begin
          m_addr  = (|(mask & {mn, mz, mp})) ? t : m_addr + 7'd1;
          tgt_now = 1'b0;
        end else begin
          if (mem[m_addr][6:4] == 3'b011) begin
            tgt_now = 1'b1;
            op_addr = m_addr;
          end
          m_addr = m_addr + 7'd1;
        end
        exp_q.push_back(mem[m_addr]);
      end
      prev_stall = stall_v;
      if (FLAG_WE) begin
        mn = FLAG_DATA[3];
        mz = (FLAG_DATA == 4'd0);
        mp = !mn && !mz;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
